// File: rtl/axis_rr_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// axis_rr_pkt_arbiter : packet-granular round-robin AXI4-stream arbiter that
// announces the granted source index on a meta channel ahead of the data.
// Revision: 1.0
// ============================================================================
module axis_rr_pkt_arbiter #(
   parameter int N_SRC           = 4,
   parameter int AXI4S_DATA_BITS = 512,
   parameter int ID_BITS         = $clog2(N_SRC)
) (
   input  logic                                 aclk,
   input  logic                                 areset,
   input  logic [N_SRC-1:0]                     s_axis_tvalid,
   output logic [N_SRC-1:0]                     s_axis_tready,
   input  logic [N_SRC*AXI4S_DATA_BITS-1:0]     s_axis_tdata,
   input  logic [N_SRC*AXI4S_DATA_BITS/8-1:0]   s_axis_tkeep,
   input  logic [N_SRC-1:0]                     s_axis_tlast,
   output logic                                 m_axis_tvalid,
   input  logic                                 m_axis_tready,
   output logic [AXI4S_DATA_BITS-1:0]           m_axis_tdata,
   output logic [AXI4S_DATA_BITS/8-1:0]         m_axis_tkeep,
   output logic                                 m_axis_tlast,
   output logic                                 m_meta_valid,
   input  logic                                 m_meta_ready,
   output logic [ID_BITS-1:0]                   m_meta_data,
   output logic [31:0]                          pkt_cnt
);

   localparam int KEEP_BITS = AXI4S_DATA_BITS / 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_META = 2'd1,
      S_XFER = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [ID_BITS-1:0]   grant_q, grant_d;
   logic [ID_BITS-1:0]   rr_ptr_q, rr_ptr_d;
   logic [31:0]          pkt_cnt_q, pkt_cnt_d;

   logic                 pick_found;
   logic [ID_BITS-1:0]   pick_idx;
   logic [ID_BITS-1:0]   scan_idx;
   logic                 beat_last;

   // Search starts at rr_ptr and wraps, so the first hit is the fair winner.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_idx   = '0;
      for (int k = 0; k < N_SRC; k++) begin
         scan_idx = ID_BITS'((32'(rr_ptr_q) + 32'(k)) % 32'(N_SRC));
         if (!pick_found && s_axis_tvalid[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      rr_ptr_d      = rr_ptr_q;
      pkt_cnt_d     = pkt_cnt_q;
      m_meta_valid  = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      beat_last     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               grant_d = pick_idx;
               state_d = S_META;
            end
         end
         S_META: begin
            m_meta_valid = 1'b1;
            if (m_meta_ready) state_d = S_XFER;
         end
         S_XFER: begin
            m_axis_tvalid          = s_axis_tvalid[grant_q];
            m_axis_tdata           = s_axis_tdata[32'(grant_q)*AXI4S_DATA_BITS +: AXI4S_DATA_BITS];
            m_axis_tkeep           = s_axis_tkeep[32'(grant_q)*KEEP_BITS +: KEEP_BITS];
            m_axis_tlast           = s_axis_tlast[grant_q];
            s_axis_tready[grant_q] = m_axis_tready;
            beat_last = s_axis_tvalid[grant_q] && m_axis_tready && s_axis_tlast[grant_q];
            // The pointer advances only when the packet finishes, not at grant.
            if (beat_last) begin
               state_d   = S_IDLE;
               rr_ptr_d  = ID_BITS'((32'(grant_q) + 32'd1) % 32'(N_SRC));
               pkt_cnt_d = pkt_cnt_q + 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         pkt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   assign m_meta_data = grant_q;
   assign pkt_cnt     = pkt_cnt_q;

endmodule
`default_nettype wire
